// File: rtl/mux_rr_reg.sv
// N-channel registered data mux with valid/ready handshakes; directed or round-robin selection.
// Optional burst lock in round-robin mode is enabled by defining MUX_RR_LOCK_EN (adds port `lock`).

module mux_rr_lane #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int IDX   = 0
) (
    input  logic             rst,
    input  logic             load_en,
    input  logic             gvalid,
    input  logic [SEL_W-1:0] gidx,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] dsel
);
    localparam logic [SEL_W-1:0] ID = IDX[SEL_W-1:0];

    logic hit;

    assign hit   = gvalid && (gidx == ID);
    assign ready = hit & load_en & !rst;
    assign dsel  = hit ? data : '0;
endmodule

module mux_rr_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef MUX_RR_LOCK_EN
    input  logic                    lock,
`endif
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);
    localparam int               NPAD     = 2 ** SEL_W;
    localparam logic [SEL_W:0]   NCH      = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_CH - 1);

    generate
        if (SEL_W != $clog2(NUM_CH) || NUM_CH < 2 || NUM_CH > 16) begin : g_bad_cfg
            $error("mux_rr_reg: NUM_CH must be 2..16 and SEL_W must equal clog2(NUM_CH)");
        end
    endgenerate

    logic [SEL_W-1:0]             last;
    logic [NPAD-1:0]              vpad;
    logic                         gvalid;
    logic [SEL_W-1:0]             gidx;
    logic [SEL_W:0]               idx;
    logic                         load_en;
    logic                         xfer;
    logic [NUM_CH-1:0][WIDTH-1:0] lane_d;
    logic [WIDTH-1:0]             mux_d;

    // Zero-padded valid vector: out-of-range sel/index reads as "not valid".
    assign vpad    = NPAD'(in_valid);
    assign load_en = !out_valid | out_ready;
    assign xfer    = |in_ready;

    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        idx    = '0;
        if (!mode) begin
            gvalid = vpad[sel];
            gidx   = sel;
        end else begin
            // Rotating search starting just after the last round-robin winner.
            for (int k = 0; k < NUM_CH; k++) begin
                idx = {1'b0, last} + (SEL_W + 1)'(k + 1);
                if (idx >= NCH) idx = idx - NCH;
                if (!gvalid && vpad[idx[SEL_W-1:0]]) begin
                    gvalid = 1'b1;
                    gidx   = idx[SEL_W-1:0];
                end
            end
`ifdef MUX_RR_LOCK_EN
            if (lock && vpad[last]) begin
                gvalid = 1'b1;
                gidx   = last;
            end
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            mux_rr_lane #(
                .WIDTH (WIDTH),
                .SEL_W (SEL_W),
                .IDX   (gi)
            ) u_lane (
                .rst     (rst),
                .load_en (load_en),
                .gvalid  (gvalid),
                .gidx    (gidx),
                .data    (in_data[gi*WIDTH +: WIDTH]),
                .ready   (in_ready[gi]),
                .dsel    (lane_d[gi])
            );
        end
    endgenerate

    always_comb begin
        mux_d = '0;
        for (int i = 0; i < NUM_CH; i++) mux_d = mux_d | lane_d[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= LAST_RST;
        end else if (xfer) begin
            out_data  <= mux_d;
            out_ch    <= gidx;
            out_valid <= 1'b1;
            if (mode) last <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed, table-driven bench for mux_rr_reg (4-channel main instance plus a 3-channel instance).
module tb_mux_rr_reg;
    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] erdy;
        logic       eov;
        logic [7:0] ed;
        logic [1:0] ech;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic        m3;
    logic [1:0]  s3;
    logic [23:0] d3;
    logic [2:0]  v3;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic        ov3;
    logic        r3;
    logic [1:0]  och3;

    int checks = 0;
    int errors = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    mux_rr_reg #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_RR_LOCK_EN
        .lock      (lock),
`endif
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    mux_rr_reg #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_RR_LOCK_EN
        .lock      (1'b0),
`endif
        .mode      (m3),
        .sel       (s3),
        .in_data   (d3),
        .in_valid  (v3),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (r3),
        .out_ch    (och3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void addv(input logic m, input logic [1:0] s, input logic [3:0] v,
                                 input logic r, input logic [3:0] er, input logic eov,
                                 input logic [7:0] ed, input logic [1:0] ech);
        vec_t x;
        x = '{m, s, v, r, er, eov, ed, ech};
        vt.push_back(x);
    endfunction

    // One cycle on the main instance: drive, check ready, clock, check output register.
    task automatic step(input string nm, input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] er, input logic eov,
                        input logic [7:0] ed, input logic [1:0] ech);
        mode = m; sel = s; in_valid = v; out_ready = r;
        #1 chk({nm, ".in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk); #1;
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(eov));
        chk({nm, ".out_data"}, 32'(out_data), 32'(ed));
        chk({nm, ".out_ch"}, 32'(out_ch), 32'(ech));
    endtask

    task automatic step3(input string nm, input logic m, input logic [1:0] s, input logic [2:0] er,
                         input logic eov, input logic [7:0] ed, input logic [1:0] ech);
        m3 = m; s3 = s; v3 = 3'b111; r3 = 1'b1;
        #1 chk({nm, ".in_ready"}, 32'(rdy3), 32'(er));
        @(posedge clk); #1;
        chk({nm, ".out_valid"}, 32'(ov3), 32'(eov));
        chk({nm, ".out_data"}, 32'(od3), 32'(ed));
        chk({nm, ".out_ch"}, 32'(och3), 32'(ech));
    endtask

    initial begin
        // ch0=11 ch1=22 ch2=A5 ch3=3C
        in_data = 32'h3CA5_2211;
        d3 = 24'h03_02_01;
        rst = 1'b1; lock = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        m3 = 1'b0; s3 = 2'd0; v3 = 3'b000; r3 = 1'b1;

        //     mode sel  vld     rdy   erdy    eov   ed     ech
        addv(1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);
        addv(1, 0, 4'hF, 1, 4'b0010, 1, 8'h22, 1);
        addv(1, 0, 4'hF, 1, 4'b0100, 1, 8'hA5, 2);
        addv(1, 0, 4'hF, 1, 4'b1000, 1, 8'h3C, 3);
        addv(1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);
        addv(1, 0, 4'hF, 1, 4'b0010, 1, 8'h22, 1);
        addv(1, 0, 4'hA, 1, 4'b1000, 1, 8'h3C, 3);
        addv(1, 0, 4'hA, 1, 4'b0010, 1, 8'h22, 1);
        addv(1, 0, 4'hA, 1, 4'b1000, 1, 8'h3C, 3);
        addv(1, 0, 4'hA, 1, 4'b0010, 1, 8'h22, 1);
        addv(0, 2, 4'hF, 1, 4'b0100, 1, 8'hA5, 2);
        addv(0, 1, 4'hF, 1, 4'b0010, 1, 8'h22, 1);
        addv(0, 2, 4'hB, 1, 4'b0000, 0, 8'h22, 1);
        addv(0, 2, 4'hB, 1, 4'b0000, 0, 8'h22, 1);
        addv(0, 3, 4'hF, 0, 4'b1000, 1, 8'h3C, 3);
        addv(0, 3, 4'hF, 0, 4'b0000, 1, 8'h3C, 3);
        addv(0, 3, 4'hF, 0, 4'b0000, 1, 8'h3C, 3);
        addv(0, 3, 4'hF, 0, 4'b0000, 1, 8'h3C, 3);
        addv(0, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);
        addv(1, 0, 4'hF, 1, 4'b0100, 1, 8'hA5, 2);
        addv(1, 0, 4'h0, 1, 4'b0000, 0, 8'hA5, 2);
        addv(1, 0, 4'h1, 0, 4'b0001, 1, 8'h11, 0);
        addv(1, 0, 4'h1, 0, 4'b0000, 1, 8'h11, 0);

        // Reset held two cycles with every channel valid.
        #1 chk("rst.in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst.in_ready2", 32'(in_ready), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data", 32'(out_data), 32'h0);
        chk("rst.out_ch", 32'(out_ch), 32'h0);
        rst = 1'b0;

        foreach (vt[i])
            step($sformatf("vec%0d", i), vt[i].mode, vt[i].sel, vt[i].vld, vt[i].ordy,
                 vt[i].erdy, vt[i].eov, vt[i].ed, vt[i].ech);

        // Reset while a stalled word is held: word discarded, pointer back to ch0 priority.
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        #1 chk("midrst.in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        chk("midrst.out_valid", 32'(out_valid), 32'h0);
        chk("midrst.out_data", 32'(out_data), 32'h0);
        chk("midrst.out_ch", 32'(out_ch), 32'h0);
        rst = 1'b0;
        step("postrst", 1, 0, 4'hF, 1, 4'b0001, 1, 8'h11, 0);

`ifdef MUX_RR_LOCK_EN
        step("lock0a", 1, 0, 4'hF, 1, 4'b0010, 1, 8'h22, 1);
        step("lock0b", 1, 0, 4'hF, 1, 4'b0100, 1, 8'hA5, 2);
        lock = 1'b1;
        step("lock1a", 1, 0, 4'hC, 1, 4'b0100, 1, 8'hA5, 2);
        step("lock1b", 1, 0, 4'hC, 1, 4'b0100, 1, 8'hA5, 2);
        lock = 1'b0;
        step("unlock", 1, 0, 4'hC, 1, 4'b1000, 1, 8'h3C, 3);
`endif

        // Three-channel instance: wrap of the round-robin pointer and out-of-range sel.
        in_valid = 4'h0;
        step3("c3.rr0", 1, 0, 3'b001, 1, 8'h01, 0);
        step3("c3.rr1", 1, 0, 3'b010, 1, 8'h02, 1);
        step3("c3.rr2", 1, 0, 3'b100, 1, 8'h03, 2);
        step3("c3.rr3", 1, 0, 3'b001, 1, 8'h01, 0);
        step3("c3.sel3a", 0, 3, 3'b000, 0, 8'h01, 0);
        step3("c3.sel3b", 0, 3, 3'b000, 0, 8'h01, 0);
        step3("c3.sel2", 0, 2, 3'b100, 1, 8'h03, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor of the 2:1 8-bit data mux: N channels, WIDTH bits each, with a registered output stage and valid/ready handshakes on every input and on the output.
- Two selection modes: directed (channel chosen by `sel`) and round-robin (fair arbitration among valid channels).
- Sits between multiple microcontroller data sources (ALU result, memory read, immediate, I/O) and a single consumer such as the register file write port or the bus.

Parameters:
- WIDTH, 8, data width per channel.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_W, 2, width of `sel` and `out_ch`; must equal clog2(NUM_CH). An elaboration-time check fails if it does not.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = directed by `sel`, 1 = round-robin.
- sel  input  SEL_W  channel index, used only when mode = 0.
- in_data  input  NUM_CH*WIDTH  flat bus; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_ch  output  SEL_W  index of the channel that supplied `out_data`.

Behaviour:
- Reset values (synchronous, rst = 1 at a rising clk edge):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer `last` = NUM_CH-1, so channel 0 has first priority.
  - in_ready = 0 while rst is high.
- Output register:
  - Single entry. `load_en = !out_valid | out_ready`.
- Grant (combinational, one-hot `grant`, at most one bit set):
  - mode 0: grant[sel] = in_valid[sel]. If sel >= NUM_CH, there is no grant.
  - mode 1: search channels `last`+1, `last`+2, ... wrapping modulo NUM_CH; the first with in_valid set wins.
  - No valid channel gives grant = 0.
- Ready and transfer:
  - in_ready[i] = load_en & grant[i] & !rst.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer (next clk edge):
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - In mode 1 only, `last` <= i.
- Latency: 1 cycle from the input transfer to out_valid.
- Drain without refill: out_valid & out_ready with no transfer gives out_valid <= 0, and out_data/out_ch hold their values.
- Simultaneous drain and load: when out_ready = 1 and out_valid = 1, a new transfer loads in the same cycle. Full throughput is 1 word per cycle.
- Stall: while out_valid & !out_ready, out_data and out_ch are stable and all in_ready = 0.
- Mode and `sel` changes:
  - They take effect on the next grant evaluation. A word already in the output register is unaffected.
  - `last` is retained across mode 0 periods.
- in_valid may drop without a transfer; there is no stickiness in mode 0 or mode 1.
- Reset mid-operation: a pending output word is discarded, all outputs return to reset values, and no transfer occurs in the reset cycle.

Optional Feature:
- Macro: MUX_RR_LOCK_EN.
- With the macro defined:
  - Extra input port `lock` (1 bit).
  - In mode 1, when lock = 1 and in_valid[`last`] = 1, the grant goes to `last`, so a multi-word burst is not interleaved. Otherwise normal round-robin applies.
  - `lock` has no effect in mode 0.
- Without the macro: the port is absent and behaviour is pure round-robin as above.

Test Plan:
- Reset: hold rst 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0000. After release, the first transfer comes from ch0.
- Directed mode: mode = 0, sel = 2, ch2 data = 0xA5, all valid, out_ready = 1 -> in_ready = 0100, next cycle out_data = 0xA5, out_ch = 2. Setting sel = 1 gives ch1 data next.
- Round-robin fairness: mode = 1, all four channels valid continuously, out_ready = 1 -> out_ch sequence 0, 1, 2, 3, 0, 1, one word per cycle. With only ch1 and ch3 valid -> 1, 3, 1, 3.
- Back-pressure: out_valid = 1 holding 0x3C, out_ready = 0 for 3 cycles -> out_data stays 0x3C and in_ready = 0000. When out_ready rises, the drain and the next load happen in the same cycle with no bubble.
- Boundary:
  - mode = 0, sel = 2, in_valid[2] = 0 -> no grant and out_valid falls after the drain.
  - With NUM_CH = 3 and sel = 3 -> no grant ever.
  - rst asserted while out_valid = 1 -> out_valid = 0 on the next edge.
- MUX_RR_LOCK_EN: mode = 1, lock = 1, ch2 last granted and still valid, ch3 valid -> ch2 is granted repeatedly. After lock drops, ch3 is granted next.
